// File: rtl/bpsk_rx.sv
// Coherent BPSK demodulator: NCO-referenced sign mixer followed by an
// integrate-and-dump stage that produces one hard decision per symbol.
module bpsk_rx #(
  parameter int SPB   = 50,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       sample_in,
  input  logic              sample_valid,
  input  logic [31:0]       phase_step,
  input  logic [31:0]       phase_offset,
  input  logic              sym_sync,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [ACC_W-1:0]  integ_out
);

  logic [31:0]              phase_acc;
  logic [31:0]              ref_phase;
  logic                     ref_pos;
  logic signed [16:0]       sample_ext;
  logic signed [16:0]       product;
  logic signed [16:0]       prod_q;
  logic                     s1_valid;
  logic                     s1_last;
  logic [15:0]              sym_cnt;
  logic                     is_last;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;

  always_comb begin
    ref_phase  = phase_acc + phase_offset;
    // Upper half of the phase circle is the negative lobe of the sine.
    ref_pos    = (ref_phase < 32'h8000_0000);
    sample_ext = {sample_in[15], sample_in};
    product    = ref_pos ? sample_ext : -sample_ext;
    // The sample taken on a sync edge is always the first of a new symbol.
    is_last    = (sym_cnt == 16'(SPB - 1)) && !sym_sync;
    sum        = acc + {{(ACC_W-17){prod_q[16]}}, prod_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc <= '0;
      sym_cnt   <= '0;
      prod_q    <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      acc       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      integ_out <= '0;
    end else begin
      bit_valid <= 1'b0;

      if (sample_valid)
        phase_acc <= phase_acc + phase_step;

      s1_valid <= sample_valid;
      s1_last  <= sample_valid && is_last;
      prod_q   <= product;

      if (sym_sync)
        sym_cnt <= sample_valid ? 16'd1 : 16'd0;
      else if (sample_valid)
        sym_cnt <= is_last ? 16'd0 : sym_cnt + 16'd1;

      // Sync drops whatever product is in flight, so the partial symbol never decides.
      if (sym_sync) begin
        acc <= '0;
      end else if (s1_valid) begin
        if (s1_last) begin
          integ_out <= sum;
          bit_out   <= (sum > 0);
          bit_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_bpsk_rx.sv
// Directed bench for bpsk_rx: decisions are logged by a monitor and each
// scenario task checks them against hand-computed integrals and timing.
module tb_bpsk_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] phase_step = '0;
  logic [31:0] phase_offset = '0;
  logic        sym_sync = 1'b0;
  logic        bit_out;
  logic        bit_valid;
  logic [31:0] integ_out;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_edge = 0;

  int ev_bit_q[$];
  int ev_integ_q[$];
  int ev_cyc_q[$];

  bpsk_rx #(.SPB(50), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .phase_step(phase_step), .phase_offset(phase_offset), .sym_sync(sym_sync),
    .bit_out(bit_out), .bit_valid(bit_valid), .integ_out(integ_out)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // decision monitor
  always @(negedge clk) begin
    if (bit_valid) begin
      ev_bit_q.push_back(int'(bit_out));
      ev_integ_q.push_back($signed(integ_out));
      ev_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    sym_sync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ev_bit_q.delete();
    ev_integ_q.delete();
    ev_cyc_q.delete();
  endtask

  task automatic drive(input logic [15:0] s, input int n, input bit sparse);
    for (int i = 0; i < n; i++) begin
      sample_in = s;
      sample_valid = 1'b1;
      tick();
      last_edge = cyc;
      if (sparse) begin
        sample_valid = 1'b0;
        tick();
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (bit_out !== 1'b0) begin errs++; $display("FAIL reset_bit_out got=%b exp=0", bit_out); end
    vecs++; if (bit_valid !== 1'b0) begin errs++; $display("FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    vecs++; if (integ_out !== 32'd0) begin errs++; $display("FAIL reset_integ got=%0d exp=0", $signed(integ_out)); end
    vecs++; if (dut.phase_acc !== 32'd0) begin errs++; $display("FAIL reset_phase got=%h exp=0", dut.phase_acc); end
  endtask

  task automatic test_constant();
    int k;
    do_reset();
    phase_step = 32'd0;
    phase_offset = 32'd0;
    drive(16'd1000, 50, 1'b0);
    k = last_edge;
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 1) begin errs++; $display("FAIL const_pos_count got=%0d exp=1", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 0) begin
      vecs++; if (ev_integ_q[0] !== 50000) begin errs++; $display("FAIL const_pos_integ got=%0d exp=50000", ev_integ_q[0]); end
      vecs++; if (ev_bit_q[0] !== 1) begin errs++; $display("FAIL const_pos_bit got=%0d exp=1", ev_bit_q[0]); end
      vecs++; if (ev_cyc_q[0] !== k + 1) begin errs++; $display("FAIL const_latency got=%0d exp=%0d", ev_cyc_q[0], k + 1); end
    end
    drive(-16'sd1000, 50, 1'b0);
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 2) begin errs++; $display("FAIL const_neg_count got=%0d exp=2", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 1) begin
      vecs++; if (ev_integ_q[1] !== -50000) begin errs++; $display("FAIL const_neg_integ got=%0d exp=-50000", ev_integ_q[1]); end
      vecs++; if (ev_bit_q[1] !== 0) begin errs++; $display("FAIL const_neg_bit got=%0d exp=0", ev_bit_q[1]); end
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    phase_step = 32'd0;
    phase_offset = 32'h8000_0000;
    drive(16'h8000, 50, 1'b0);
    drive(16'h0000, 50, 1'b0);
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 2) begin errs++; $display("FAIL fs_count got=%0d exp=2", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 1) begin
      vecs++; if (ev_integ_q[0] !== 1638400) begin errs++; $display("FAIL fs_integ got=%0d exp=1638400", ev_integ_q[0]); end
      vecs++; if (ev_bit_q[0] !== 1) begin errs++; $display("FAIL fs_bit got=%0d exp=1", ev_bit_q[0]); end
      vecs++; if (ev_integ_q[1] !== 0) begin errs++; $display("FAIL zero_integ got=%0d exp=0", ev_integ_q[1]); end
      vecs++; if (ev_bit_q[1] !== 0) begin errs++; $display("FAIL zero_bit got=%0d exp=0", ev_bit_q[1]); end
    end
    phase_offset = 32'd0;
  endtask

  task automatic test_sparse();
    do_reset();
    phase_step = 32'd1000;
    phase_offset = 32'd0;
    drive(16'd1000, 100, 1'b1);
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 2) begin errs++; $display("FAIL sparse_count got=%0d exp=2", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 1) begin
      vecs++; if (ev_integ_q[0] !== 50000) begin errs++; $display("FAIL sparse_integ got=%0d exp=50000", ev_integ_q[0]); end
      vecs++; if (ev_cyc_q[1] - ev_cyc_q[0] !== 100) begin errs++; $display("FAIL sparse_period got=%0d exp=100", ev_cyc_q[1] - ev_cyc_q[0]); end
    end
    vecs++; if (dut.phase_acc !== 32'd100000) begin errs++; $display("FAIL sparse_phase got=%0d exp=100000", dut.phase_acc); end
    phase_step = 32'd0;
  endtask

  task automatic test_sync();
    int k;
    do_reset();
    phase_step = 32'd0;
    drive(16'd1000, 20, 1'b0);
    sym_sync = 1'b1;
    sample_in = 16'd1000;
    sample_valid = 1'b1;
    tick();
    sym_sync = 1'b0;
    drive(16'd1000, 49, 1'b0);
    k = last_edge;
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 1) begin errs++; $display("FAIL sync_count got=%0d exp=1", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 0) begin
      vecs++; if (ev_integ_q[0] !== 50000) begin errs++; $display("FAIL sync_integ got=%0d exp=50000", ev_integ_q[0]); end
      vecs++; if (ev_cyc_q[0] !== k + 1) begin errs++; $display("FAIL sync_latency got=%0d exp=%0d", ev_cyc_q[0], k + 1); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    phase_step = 32'd0;
    drive(16'd1000, 30, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (bit_valid !== 1'b0 || integ_out !== 32'd0 || bit_out !== 1'b0) begin
      errs++; $display("FAIL rst_mid_outputs got=%b/%b/%0d exp=0/0/0", bit_valid, bit_out, $signed(integ_out));
    end
    drive(-16'sd1000, 50, 1'b0);
    k = last_edge;
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 1) begin errs++; $display("FAIL rst_mid_count got=%0d exp=1", ev_cyc_q.size()); end
    if (ev_cyc_q.size() > 0) begin
      vecs++; if (ev_integ_q[0] !== -50000) begin errs++; $display("FAIL rst_mid_integ got=%0d exp=-50000", ev_integ_q[0]); end
      vecs++; if (ev_cyc_q[0] !== k + 1) begin errs++; $display("FAIL rst_mid_latency got=%0d exp=%0d", ev_cyc_q[0], k + 1); end
    end
    // reset lands on the edge where the decision would be made
    drive(16'd1000, 50, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 1) begin errs++; $display("FAIL rst_pending_count got=%0d exp=1", ev_cyc_q.size()); end
    vecs++; if (integ_out !== 32'd0) begin errs++; $display("FAIL rst_pending_integ got=%0d exp=0", $signed(integ_out)); end
  endtask

  task automatic test_back_to_back();
    int pattern[7] = '{1, 1, 0, 0, 1, 0, 1};
    int g;
    int s;
    do_reset();
    // half-cycle carrier: reference is + on even samples, - on odd samples
    phase_step = 32'h8000_0000;
    phase_offset = 32'd0;
    g = 0;
    for (int b = 0; b < 7; b++) begin
      for (int n = 0; n < 50; n++) begin
        s = (g % 2 == 0) ? 500 : -500;
        if (pattern[b] == 0) s = -s;
        sample_in = 16'(s);
        sample_valid = 1'b1;
        tick();
        g++;
      end
    end
    sample_valid = 1'b0;
    repeat (4) tick();
    vecs++; if (ev_cyc_q.size() !== 7) begin errs++; $display("FAIL b2b_count got=%0d exp=7", ev_cyc_q.size()); end
    for (int i = 0; i < ev_cyc_q.size() && i < 7; i++) begin
      vecs++; if (ev_bit_q[i] !== pattern[i]) begin errs++; $display("FAIL b2b_bit%0d got=%0d exp=%0d", i, ev_bit_q[i], pattern[i]); end
      vecs++; if (ev_integ_q[i] !== (pattern[i] == 1 ? 25000 : -25000)) begin
        errs++; $display("FAIL b2b_integ%0d got=%0d exp=%0d", i, ev_integ_q[i], (pattern[i] == 1 ? 25000 : -25000));
      end
      if (i > 0) begin
        vecs++; if (ev_cyc_q[i] - ev_cyc_q[i-1] !== 50) begin errs++; $display("FAIL b2b_period%0d got=%0d exp=50", i, ev_cyc_q[i] - ev_cyc_q[i-1]); end
      end
    end
    phase_step = 32'd0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_full_scale();
    test_sparse();
    test_sync();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bpsk_rx.md
# bpsk_rx

- Coherent BPSK demodulator; the receive-side counterpart of `bpsk_tx` in the BPSK modem.
- Consumes the signed 16-bit passband samples `bpsk_tx` produces and regenerates the carrier with a local 32-bit phase accumulator driven by the same `phase_step` word.
- Mixes each sample with the sign of the local sine, integrates over a fixed number of samples per bit (integrate-and-dump), and emits one hard bit decision plus the raw integral per symbol.
- Carrier phase and symbol timing are externally aligned through `phase_offset` and `sym_sync`; this block does no carrier or timing recovery.

## Interface
Parameters:
- `SPB`, 50: accepted samples per bit; legal range 2..65535.
- `ACC_W`, 32: integrator and `integ_out` width. Must satisfy ACC_W ≥ 17 + ceil(log2(SPB)).

Ports:
- `clk`  in  1: single clock; everything is synchronous to its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sample_in`  in  16: signed two's-complement passband sample.
- `sample_valid`  in  1: `sample_in` is accepted on this edge.
- `phase_step`  in  32: carrier phase increment per accepted sample; unsigned, wraps mod 2^32.
- `phase_offset`  in  32: constant phase added to the accumulator before reference extraction.
- `sym_sync`  in  1: single-cycle pulse that restarts symbol integration.
- `bit_out`  out  1: decided bit; held until the next decision.
- `bit_valid`  out  1: one-cycle strobe, high for exactly one cycle per decision.
- `integ_out`  out  ACC_W: signed integral of the completed symbol; held with `bit_out`.

## Operation
- **NCO.** `phase_acc` is a 32-bit register, reset to 0.
  - On each accepted sample, `ref_pos = ~(phase_acc + phase_offset)[31]`, computed from the pre-update value.
  - Then `phase_acc <= phase_acc + phase_step`, mod 2^32.
  - `phase_acc` holds when `sample_valid` = 0. `sym_sync` does not affect it.
- **Mixer (stage 1).** The product is 17 bits signed: `sample_in` sign-extended if `ref_pos`, negated otherwise.
  - -32768 negates to +32768 with no saturation.
  - Registered together with a valid flag and a `last` flag.
- **Symbol counter.** `sym_cnt` is 16 bits, reset to 0, and counts accepted samples 0..SPB-1.
  - The sample accepted while `sym_cnt` = SPB-1 is tagged `last`; the counter then wraps to 0.
- **Integrator (stage 2).** When stage 1 is valid, `acc <= acc + sext(product)`.
  - If `last`: sum = acc + product, then `integ_out <= sum`, `bit_out <= (sum > 0)`, `bit_valid <= 1`, `acc <= 0`.
  - A sum of exactly 0 decides 0.
  - Bit mapping matches `bpsk_tx`: bit 1 is carrier in phase with sine, bit 0 is inverted.
- **`sym_sync`** on an edge:
  - `acc` is cleared and any stage-1 product pending at that edge is discarded, so no `bit_valid` is issued for the partial symbol.
  - `sym_cnt` becomes 1 if `sample_valid` is high on the same edge (that sample is the first of the new symbol and is mixed normally), otherwise 0.
- **Reset.** `phase_acc`, `sym_cnt`, `acc`, stage-1 valid, `bit_out`, `bit_valid` and `integ_out` all go to 0. Reset takes priority over `sym_sync` and `sample_valid`.
- **Overflow.** None when the ACC_W rule holds; the design requires no overflow detection.

## Timing
- **Latency.** If the `last` sample of a symbol is accepted at edge k, then `bit_valid` = 1 for the cycle after edge k+1. This is 2 edges.
- **Throughput.** One sample per clock, with no back-pressure. `bit_valid` can recur every SPB cycles at full rate.
- **Gaps.** Gaps in `sample_valid` stall the NCO and the counter but not the pipeline drain. A product already in stage 1 is still integrated on the next edge.
- **Reset mid-symbol.** Reset asserted at any point discards the partial symbol. After release, the first accepted sample is sample 0 at phase `phase_offset`.
- **Reset with a pending decision.** Reset asserted on the same edge a decision would occur suppresses that `bit_valid`.

## Test plan
- **Constant input, in-phase reference.** `phase_step`=0, `phase_offset`=0, SPB=50; `sample_in`=+1000 continuously for 50 samples -> `integ_out`=50000, `bit_out`=1, single `bit_valid` 2 edges after sample 50. Then -1000 -> `integ_out`=-50000, `bit_out`=0.
- **Full-scale negative with inverted reference.** `phase_offset`=0x80000000 (ref=-1), `sample_in`=-32768 ×50 -> `integ_out`=+1638400, `bit_out`=1. Zero input ×50 -> `integ_out`=0, `bit_out`=0.
- **Modem loopback.** `bpsk_tx` (50 MHz clk, `phase_step`=85899346) drives `sample_in` with `sample_valid`=1 and pattern 1 1 0 0 1 0 1, one bit per 50 clocks; `phase_offset` is set to compensate TX latency and `sym_sync` is pulsed at the first bit boundary -> `bit_out` sequence 1 1 0 0 1 0 1, `bit_valid` every 50 cycles.
- **Sparse `sample_valid`.** `sample_valid` alternates 1/0 with constant +1000 -> `bit_valid` every 100 cycles, `integ_out`=50000, and `phase_acc` advances only 50 steps per symbol.
- **Sync mid-symbol.** `sym_sync` after 20 samples of +1000, with `sample_valid` high on the sync edge -> no decision for the partial symbol. The next `bit_valid` comes 2 edges after the 50th sample counted from the sync-edge sample, with `integ_out`=50000.
- **Reset mid-symbol.** `rst` for 1 cycle after 30 samples -> all outputs 0, no stale `bit_valid`. The following 50 samples of -1000 give `integ_out`=-50000.
